vedic_div_4x2: RTL and testbench

VEDIC_DIV_4X2 -- requirements
Module: vedic_div_4x2

---
 rtl/vedic_pkg.sv | 11 +
 rtl/vedic_div_4x2_if.sv | 21 ++
 rtl/vedic_mul_4x2.sv | 10 +
 rtl/vedic_div_4x2.sv | 83 ++++++++
 tb/tb_vedic_div_4x2.sv | 124 ++++++++++++
 5 files changed

// File: rtl/vedic_pkg.sv
// vedic_pkg: shared FSM state type, default widths and the 2x2 vedic multiply cell.
package vedic_pkg;
  localparam int DVD_W_DEF = 4;
  localparam int DVS_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
    logic c;
    c = a[1] & b[0] & a[0] & b[1];
    return {a[1] & b[1] & c, (a[1] & b[1]) ^ c, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
  endfunction
endpackage

// File: rtl/vedic_div_4x2_if.sv
// vedic_div_4x2_if: divider request/result bus; selfcheck_err exists only with VEDIC_DIV_SELFCHECK_EN.
interface vedic_div_4x2_if
  import vedic_pkg::*;
#(parameter int DVD_W = DVD_W_DEF, parameter int DVS_W = DVS_W_DEF);
  logic start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic busy;
  logic done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic div_by_zero;
`ifdef VEDIC_DIV_SELFCHECK_EN
  logic selfcheck_err;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero, selfcheck_err);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero, selfcheck_err);
`else
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/vedic_mul_4x2.sv
// vedic_mul_4x2: combinational 4x2 multiplier assembled from two 2x2 vedic cells.
module vedic_mul_4x2
  import vedic_pkg::*;
(
  input  logic [3:0] a,
  input  logic [1:0] b,
  output logic [5:0] p
);
  assign p = {vedic_2x2(a[3:2], b), 2'b00} + 6'(vedic_2x2(a[1:0], b));
endmodule

// File: rtl/vedic_div_4x2.sv
// vedic_div_4x2: restoring divider, one quotient bit per clock, MSB first.
// VEDIC_DIV_SELFCHECK_EN adds a quotient*divisor+remainder check driving selfcheck_err.
module vedic_div_4x2
  import vedic_pkg::*;
#(parameter int DVD_W = DVD_W_DEF, parameter int DVS_W = DVS_W_DEF)
(
  input logic clk,
  input logic rst_n,
  vedic_div_4x2_if.slave bus
);
  localparam int CW = $clog2(DVD_W + 1);
  state_t state;
  logic [DVD_W-1:0] work, quotient_r;
  logic [DVS_W-1:0] dvs, remainder_r;
  logic [DVS_W:0] pr, shifted, trial, pr_next;
  logic [CW-1:0] cnt;
  logic busy_r, done_r, dbz_r, acc, qbit, last;
  assign acc = bus.start && state != CALC;
  assign shifted = {pr[DVS_W-1:0], work[DVD_W-1]};
  assign trial = shifted - {1'b0, dvs};
  assign qbit = pr[DVS_W] | (shifted >= {1'b0, dvs});
  assign pr_next = qbit ? trial : shifted;
  assign last = cnt == CW'(DVD_W - 1);
  // work starts as the dividend and fills with quotient bits as dividend bits shift out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      dvs <= '0;
      pr <= '0;
      cnt <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r <= 1'b0;
      quotient_r <= '0;
      remainder_r <= '0;
    end else if (acc) begin
      state <= bus.divisor == '0 ? FIN : CALC;
      work <= bus.dividend;
      dvs <= bus.divisor;
      pr <= '0;
      cnt <= '0;
      busy_r <= bus.divisor != '0;
      done_r <= bus.divisor == '0;
      dbz_r <= bus.divisor == '0;
      quotient_r <= bus.divisor == '0 ? '1 : quotient_r;
      remainder_r <= bus.divisor == '0 ? '0 : remainder_r;
    end else if (state == CALC) begin
      state <= last ? FIN : CALC;
      work <= {work[DVD_W-2:0], qbit};
      pr <= pr_next;
      cnt <= cnt + CW'(1);
      busy_r <= !last;
      done_r <= last;
      quotient_r <= last ? {work[DVD_W-2:0], qbit} : quotient_r;
      remainder_r <= last ? pr_next[DVS_W-1:0] : remainder_r;
    end else begin
      state <= IDLE;
      done_r <= 1'b0;
    end
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.quotient = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_by_zero = dbz_r;
`ifdef VEDIC_DIV_SELFCHECK_EN
  logic [DVD_W-1:0] dvd_l;
  logic [5:0] prod;
  logic sc_r, chk;
  vedic_mul_4x2 u_mul (.a(quotient_r), .b(dvs), .p(prod));
  // flagged combinationally during FIN, then held by sc_r until the next accept
  assign chk = state == FIN && !dbz_r && (prod + 6'(remainder_r)) != 6'(dvd_l);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sc_r <= 1'b0;
      dvd_l <= '0;
    end else if (acc) begin
      sc_r <= 1'b0;
      dvd_l <= bus.dividend;
    end else if (chk) sc_r <= 1'b1;
  assign bus.selfcheck_err = sc_r | chk;
`endif
endmodule

// File: tb/tb_vedic_div_4x2.sv
// tb_vedic_div_4x2: scoreboard bench; timing checked in the driver, results checked by a done monitor.
module tb_vedic_div_4x2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [3:0] q; logic [1:0] r; logic z; logic s;} exp_t;
  exp_t sb[$];
  exp_t e;
  vedic_div_4x2_if bus ();
  vedic_div_4x2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_busy"}, bus.busy, 0);
    chk({n, "_done"}, bus.done, 0);
    chk({n, "_q"}, bus.quotient, 0);
    chk({n, "_r"}, bus.remainder, 0);
    chk({n, "_dbz"}, bus.div_by_zero, 0);
`ifdef VEDIC_DIV_SELFCHECK_EN
    chk({n, "_sc"}, bus.selfcheck_err, 0);
`endif
  endtask

  // called at a negedge; done is expected at the 5th (or 1st for divisor 0) following negedge
  task automatic run(input logic [3:0] a, input logic [1:0] b, input logic [3:0] q,
                     input logic [1:0] r, input logic z, input logic s);
    int lat = (b == 2'd0) ? 1 : 5;
    sb.push_back('{q, r, z, s});
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      chk("busy", bus.busy, 8'(k < lat));
      chk("done", bus.done, 8'(k == lat));
    end
  endtask

  always @(negedge clk)
    if (bus.done) begin
      if (sb.size() == 0) chk("extra_done", bus.done, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", bus.div_by_zero, e.z);
`ifdef VEDIC_DIV_SELFCHECK_EN
        chk("selfcheck_err", bus.selfcheck_err, e.s);
`endif
      end
    end

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");
    run(13, 3, 4, 1, 0, 0);
    @(negedge clk);
    run(9, 0, 15, 0, 1, 0);
    @(negedge clk);
    run(2, 3, 0, 2, 0, 0);
    run(15, 1, 15, 0, 0, 0);
    run(14, 3, 4, 2, 0, 0);
    run(0, 1, 0, 0, 0, 0);
    run(15, 3, 5, 0, 0, 0);
    run(15, 2, 7, 1, 0, 0);
    repeat (2) @(negedge clk);
    sb.push_back('{4'd5, 2'd1, 1'b0, 1'b0});
    bus.start = 1'b1;
    bus.dividend = 11;
    bus.divisor = 2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = k == 1;
      if (k == 1) begin
        bus.dividend = 3;
        bus.divisor = 1;
      end
      chk("ign_done", bus.done, 8'(k == 5));
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 7;
    bus.divisor = 3;
    repeat (2) @(negedge clk) bus.start = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("mid_release");
    run(6, 2, 3, 0, 0, 0);
`ifdef VEDIC_DIV_SELFCHECK_EN
    @(negedge clk);
    force dut.quotient_r = 4'd5;
    run(6, 2, 5, 0, 0, 1);
    release dut.quotient_r;
`endif
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 4; b++)
        run(4'(a), 2'(b), b == 0 ? 4'd15 : 4'(a / b), b == 0 ? 2'd0 : 2'(a % b), b == 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drain", 8'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
